// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, empty/almost-empty/level flags and underflow pulse for an async FIFO.
module fifo_rd_ctrl #(
  parameter int fifo_depth      = 8,
  parameter int addr_size       = $clog2(fifo_depth),
  parameter int almost_empty_th = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rinc,
  input  logic [addr_size:0]   rq2_wptr,
  output logic [addr_size-1:0] raddr,
  output logic [addr_size:0]   rptr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [addr_size:0]   rlevel,
  output logic                 rd_underflow
);
  localparam int P = addr_size + 1;
  logic [P-1:0] rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d, wbin;
  logic rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d, rd_underflow_q, rd_underflow_d, rd_en;
  always_comb begin
    rd_en = rinc & ~rempty_q;
    rbin_d = rbin_q + P'(rd_en);
    rptr_d = (rbin_d >> 1) ^ rbin_d;
    wbin = '0;
    for (int i = 0; i < P; i++) wbin[i] = ^(rq2_wptr >> i);
    rlevel_d = wbin - rbin_d;
    ralmost_empty_d = rlevel_d <= P'(almost_empty_th);
    rempty_d = rptr_d == rq2_wptr;
    rd_underflow_d = rinc & rempty_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rbin_q <= '0;
      rptr_q <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rd_underflow_q <= 1'b0;
    end else begin
      rbin_q <= rbin_d;
      rptr_q <= rptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end
  assign raddr = rbin_q[addr_size-1:0];
  assign rptr = rptr_q;
  assign rempty = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel = rlevel_q;
  assign rd_underflow = rd_underflow_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed rows push hand-computed expectations; a monitor pops and checks after each edge.
module tb_fifo_rd_ctrl;
  logic clk = 1'b0, rst = 1'b0, rinc = 1'b0;
  logic [3:0] rq2_wptr = '0;
  logic [2:0] raddr;
  logic [3:0] rptr, rlevel;
  logic rempty, ralmost_empty, rd_underflow;
  typedef struct packed {
    logic [7:0] id;
    logic [2:0] ra;
    logic [3:0] rp;
    logic e, a;
    logic [3:0] l;
    logic u;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, n = 0;
  fifo_rd_ctrl #(.fifo_depth(8), .addr_size(3), .almost_empty_th(2)) dut (
    .clk(clk), .rst(rst), .rinc(rinc), .rq2_wptr(rq2_wptr), .raddr(raddr), .rptr(rptr),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rd_underflow(rd_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask
  task automatic row(input logic r, input logic ri, input logic [3:0] w, input logic [2:0] ra,
                     input logic [3:0] rp, input logic e, input logic a, input logic [3:0] l, input logic u);
    @(negedge clk);
    rst = r;
    rinc = ri;
    rq2_wptr = w;
    n++;
    q.push_back('{id: 8'(n), ra: ra, rp: rp, e: e, a: a, l: l, u: u});
  endtask
  initial forever begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk("raddr", int'(x.id), {1'b0, raddr}, {1'b0, x.ra});
      chk("rptr", int'(x.id), rptr, x.rp);
      chk("rempty", int'(x.id), {3'b0, rempty}, {3'b0, x.e});
      chk("ralmost_empty", int'(x.id), {3'b0, ralmost_empty}, {3'b0, x.a});
      chk("rlevel", int'(x.id), rlevel, x.l);
      chk("rd_underflow", int'(x.id), {3'b0, rd_underflow}, {3'b0, x.u});
    end
  end
  initial begin
    row(0, 1, 4'b0010, 0, 4'b0000, 1, 1, 0, 0);
    row(0, 1, 4'b0010, 0, 4'b0000, 1, 1, 0, 0);
    row(1, 0, 4'b0010, 0, 4'b0000, 0, 0, 3, 0);
    row(1, 1, 4'b0010, 1, 4'b0001, 0, 1, 2, 0);
    row(1, 1, 4'b0010, 2, 4'b0011, 0, 1, 1, 0);
    row(1, 1, 4'b0010, 3, 4'b0010, 1, 1, 0, 0);
    row(1, 1, 4'b0010, 3, 4'b0010, 1, 1, 0, 1);
    row(1, 1, 4'b0010, 3, 4'b0010, 1, 1, 0, 1);
    row(1, 0, 4'b0010, 3, 4'b0010, 1, 1, 0, 0);
    row(0, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    row(1, 0, 4'b0001, 0, 4'b0000, 0, 1, 1, 0);
    row(1, 0, 4'b0011, 0, 4'b0000, 0, 1, 2, 0);
    row(1, 0, 4'b0010, 0, 4'b0000, 0, 0, 3, 0);
    row(1, 0, 4'b0110, 0, 4'b0000, 0, 0, 4, 0);
    row(1, 0, 4'b0111, 0, 4'b0000, 0, 0, 5, 0);
    row(1, 0, 4'b0101, 0, 4'b0000, 0, 0, 6, 0);
    row(1, 0, 4'b0100, 0, 4'b0000, 0, 0, 7, 0);
    row(1, 0, 4'b1100, 0, 4'b0000, 0, 0, 8, 0);
    row(1, 1, 4'b1100, 1, 4'b0001, 0, 0, 7, 0);
    row(1, 1, 4'b1100, 2, 4'b0011, 0, 0, 6, 0);
    row(1, 1, 4'b1100, 3, 4'b0010, 0, 0, 5, 0);
    row(1, 1, 4'b1100, 4, 4'b0110, 0, 0, 4, 0);
    row(1, 1, 4'b1100, 5, 4'b0111, 0, 0, 3, 0);
    row(1, 1, 4'b1100, 6, 4'b0101, 0, 1, 2, 0);
    row(1, 1, 4'b1100, 7, 4'b0100, 0, 1, 1, 0);
    row(1, 1, 4'b1100, 0, 4'b1100, 1, 1, 0, 0);
    row(1, 0, 4'b1000, 0, 4'b1100, 0, 0, 7, 0);
    row(1, 1, 4'b1000, 1, 4'b1101, 0, 0, 6, 0);
    row(1, 1, 4'b1000, 2, 4'b1111, 0, 0, 5, 0);
    row(1, 1, 4'b1000, 3, 4'b1110, 0, 0, 4, 0);
    row(1, 1, 4'b1000, 4, 4'b1010, 0, 0, 3, 0);
    row(1, 1, 4'b1000, 5, 4'b1011, 0, 1, 2, 0);
    row(1, 1, 4'b0000, 6, 4'b1001, 0, 1, 2, 0);
    row(1, 1, 4'b0000, 7, 4'b1000, 0, 1, 1, 0);
    row(1, 1, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    row(1, 1, 4'b0000, 0, 4'b0000, 1, 1, 0, 1);
    row(1, 0, 4'b0001, 0, 4'b0000, 0, 1, 1, 0);
    row(1, 0, 4'b0011, 0, 4'b0000, 0, 1, 2, 0);
    row(1, 0, 4'b0010, 0, 4'b0000, 0, 0, 3, 0);
    row(1, 0, 4'b0110, 0, 4'b0000, 0, 0, 4, 0);
    row(1, 0, 4'b0111, 0, 4'b0000, 0, 0, 5, 0);
    row(1, 0, 4'b0101, 0, 4'b0000, 0, 0, 6, 0);
    row(1, 1, 4'b0101, 1, 4'b0001, 0, 0, 5, 0);
    row(1, 1, 4'b0101, 2, 4'b0011, 0, 0, 4, 0);
    row(1, 1, 4'b0101, 3, 4'b0010, 0, 0, 3, 0);
    row(1, 1, 4'b0101, 4, 4'b0110, 0, 1, 2, 0);
    row(1, 1, 4'b0101, 5, 4'b0111, 0, 1, 1, 0);
    row(0, 1, 4'b0101, 0, 4'b0000, 1, 1, 0, 0);
    row(1, 0, 4'b0101, 0, 4'b0000, 0, 0, 6, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
